// File: rtl/nonrestoring_divider.sv
// Signed non-restoring divider: DATA_WIDTH iterations on operand magnitudes,
// then one correction/sign cycle and a one-cycle done pulse.
module nonrestoring_divider #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [W:0]    prem_q, prem_d;      // two's-complement partial remainder, bit W is the sign
    logic [W-1:0]  aq_q, aq_d;          // dividend bits shift out of the top, quotient bits in at the bottom
    logic [W-1:0]  mag_q, mag_d;
    logic          qsign_q, qsign_d;
    logic          rsign_q, rsign_d;
    logic          dz_q, dz_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          dbz_q, dbz_d;
    logic [W-1:0]  quot_q, quot_d;
    logic [W-1:0]  rem_q, rem_d;

    logic [W:0]    shifted;
    logic [W:0]    stepped;
    logic [W-1:0]  r_mag;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        prem_d  = prem_q;
        aq_d    = aq_q;
        mag_d   = mag_q;
        qsign_d = qsign_q;
        rsign_d = rsign_q;
        dz_d    = dz_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        quot_d  = quot_q;
        rem_d   = rem_q;

        shifted = {prem_q[W-1:0], aq_q[W-1]};
        stepped = prem_q[W] ? (shifted + {1'b0, mag_q}) : (shifted - {1'b0, mag_q});
        r_mag   = prem_q[W] ? (prem_q[W-1:0] + mag_q) : prem_q[W-1:0];

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    // Negation of the most-negative value yields 2^(W-1) read as unsigned.
                    aq_d    = dividend[W-1] ? -dividend : dividend;
                    mag_d   = divisor[W-1] ? -divisor : divisor;
                    qsign_d = dividend[W-1] ^ divisor[W-1];
                    rsign_d = dividend[W-1];
                    dz_d    = (divisor == '0);
                    prem_d  = '0;
                    count_d = CW'(W);
                    busy_d  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                prem_d  = stepped;
                aq_d    = {aq_q[W-2:0], ~stepped[W]};
                count_d = count_q - 1'b1;
                if (count_q == CW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                quot_d  = dz_q ? '1 : (qsign_q ? -aq_q : aq_q);
                rem_d   = rsign_q ? -r_mag : r_mag;
                dbz_d   = dz_q;
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            prem_q  <= '0;
            aq_q    <= '0;
            mag_q   <= '0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            prem_q  <= prem_d;
            aq_q    <= aq_d;
            mag_q   <= mag_d;
            qsign_q <= qsign_d;
            rsign_q <= rsign_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Self-checking bench for nonrestoring_divider (DATA_WIDTH=32) against a
// plain-arithmetic reference model.
module tb_nonrestoring_divider;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int n_assert = 0;
    int n_fail   = 0;

    nonrestoring_divider #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .quotient(quotient), .remainder(remainder)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Truncating signed division; zero divisor and overflow handled explicitly.
    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
        int sa, sb;
        sa = a;
        sb = b;
        if (sb == 0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (a == 32'h8000_0000 && sb == -1) begin
            q = 32'h8000_0000;
            r = 32'h0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eq, er;
        int  cyc;
        bit  seen;
        model(a, b, eq, er);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        seen = 0;
        cyc  = 0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                cyc  = c;
            end else begin
                chk("busy_during_op", busy, 1);
                start    = 1'(($urandom_range(0, 1)));
                dividend = $urandom;
                divisor  = $urandom;
            end
        end
        start = 1'b0;
        chk("done_cycle", cyc, 34);
        chk("busy_at_done", busy, 1);
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        chk("div_by_zero", div_by_zero, (b == 0));
        $display("div %08h / %08h -> q=%08h r=%08h dz=%0d (cycle %0d)", a, b, quotient, remainder, div_by_zero, cyc);
        @(negedge clk);
        chk("done_single_pulse", done, 0);
        chk("busy_after_done", busy, 0);
        chk("quotient_hold", quotient, eq);
        chk("remainder_hold", remainder, er);
    endtask

    initial begin
        logic [31:0] eq1, er1, eq2, er2, a, b;
        int gap, ndone;
        bit seen;

        reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dbz", div_by_zero, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        @(negedge clk);
        reset = 1'b0;

        // Directed cases
        run_div(32'd100, 32'd7);
        run_div(-32'sd100, 32'd7);
        run_div(32'd100, -32'sd7);
        run_div(-32'sd100, -32'sd7);
        run_div(32'd5, 32'd0);
        run_div(-32'sd5, 32'd0);
        run_div(32'h8000_0000, 32'hFFFF_FFFF);
        run_div(32'h8000_0000, 32'd2);
        run_div(32'h8000_0000, 32'h8000_0000);
        run_div(32'h8000_0000, 32'd0);
        run_div(32'd0, 32'd5);
        run_div(32'd6, 32'h8000_0000);

        // Random cases, half with small divisors
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = (i % 2 == 0) ? $urandom : 32'($signed($urandom_range(0, 40)) - 20);
            run_div(a, b);
        end

        // Back-to-back with start held high
        model(32'd1000, 32'd33, eq1, er1);
        model(-32'sd77, 32'd5, eq2, er2);
        @(negedge clk);
        dividend = 32'd1000; divisor = 32'd33; start = 1'b1;
        @(posedge clk);
        #1;
        dividend = -32'sd77; divisor = 32'd5;
        seen = 0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("b2b_first_seen", seen, 1);
        chk("b2b_first_q", quotient, eq1);
        chk("b2b_first_r", remainder, er1);
        seen = 0;
        gap  = 0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                gap  = c;
            end
        end
        start = 1'b0;
        chk("b2b_gap", gap, 35);
        chk("b2b_second_q", quotient, eq2);
        chk("b2b_second_r", remainder, er2);
        $display("back-to-back gap=%0d q=%08h r=%08h", gap, quotient, remainder);
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("b2b_no_extra_done", ndone, 0);

        // Abort mid-operation; reset also wins over a simultaneous start
        @(negedge clk);
        dividend = 32'd999; divisor = 32'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_dbz", div_by_zero, 0);
        chk("abort_quotient", quotient, 0);
        chk("abort_remainder", remainder, 0);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        $display("abort: busy=%0d q=%08h no-done-count=%0d", busy, quotient, ndone);
        run_div(32'd123456, 32'd789);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
